// File: rtl/tx_block_framer_if.sv
`default_nettype none
// ============================================================================
// Module   : aurora_pkg / tx_block_framer_if
// Desc     : Block-kind encoding shared with data_controller, and the block
//            bus between the data source and the tx_block_framer.
// Revision : 1.0 - initial release
// ============================================================================

`ifndef AXI_DATA_SIZE
`define AXI_DATA_SIZE 64
`endif

package aurora_pkg;
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        DATA      = 3'd1,
        NATIVE_FC = 3'd2,
        USER_FC   = 3'd3,
        CLK_COMP  = 3'd4,
        USER_K    = 3'd5
    } ordered_sets_e;
endpackage

interface tx_block_framer_if;
    import aurora_pkg::*;

    logic                      in_strobe;
    ordered_sets_e             ordered_sets;
    logic [`AXI_DATA_SIZE-1:0] data_in;
    logic [65:0]               blk_out;
    logic                      blk_valid;
    logic                      cc_active;

    modport master (
        output in_strobe, ordered_sets, data_in,
        input  blk_out, blk_valid, cc_active
    );

    modport slave (
        input  in_strobe, ordered_sets, data_in,
        output blk_out, blk_valid, cc_active
    );
endinterface

`default_nettype wire

// File: rtl/tx_block_framer.sv
`default_nettype none
// ============================================================================
// Module   : tx_block_framer
// Desc     : 64b/66b framer: sync header + x^58+x^39+1 scrambler, one-cycle
//            latency. Define CC_INSERT_EN to compile in periodic CC insertion.
// Revision : 1.0 - initial release
// ============================================================================
module tx_block_framer
    import aurora_pkg::*;
#(
    parameter int unsigned CC_PERIOD = 5000,
    parameter int unsigned CC_LEN    = 3
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    input  wire logic          single_lane,
    output logic               lane_mode,
    tx_block_framer_if.slave   bus
);

    localparam logic [57:0] SCR_SEED    = 58'h3FF_FFFF_FFFF_FFFF;
    localparam logic [1:0]  SYNC_DATA   = 2'b01;
    localparam logic [1:0]  SYNC_CTRL   = 2'b10;

    logic [57:0] scr_q, scr_d;
    logic [57:0] scr_tmp;
    logic [63:0] scr_out;
    logic [63:0] payload_sel;
    logic [1:0]  sync_sel;
    logic        cc_sel;

    logic [65:0] blk_out_q, blk_out_d;
    logic        blk_valid_q, blk_valid_d;
    logic        lane_mode_q, lane_mode_d;

`ifdef CC_INSERT_EN
    typedef enum logic [1:0] {
        ST_COUNT   = 2'd0,
        ST_PENDING = 2'd1,
        ST_INSERT  = 2'd2
    } cc_state_e;

    localparam logic [63:0] CC_PAYLOAD = 64'h7880_0000_0000_0000;
    localparam logic [15:0] CNT_LAST   = 16'(CC_PERIOD - 1);
    localparam logic [2:0]  REM_INIT   = 3'(CC_LEN - 1);

    cc_state_e   state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  rem_q, rem_d;
    logic        cnt_wrap;
    logic        is_idle;
    logic        cc_active_q, cc_active_d;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        cc_sel   = 1'b0;
        cnt_wrap = (cnt_q == CNT_LAST);
        is_idle  = (bus.ordered_sets == IDLE);
        if (bus.in_strobe) begin
            cnt_d = cnt_wrap ? 16'd0 : cnt_q + 16'd1;
            // A wrap only matters in COUNT; later wraps never queue a second request.
            case (state_q)
                ST_COUNT: begin
                    if (cnt_wrap) begin
                        state_d = ST_PENDING;
                    end
                end
                ST_PENDING: begin
                    if (is_idle) begin
                        cc_sel = 1'b1;
                        if (CC_LEN == 1) begin
                            state_d = ST_COUNT;
                        end else begin
                            state_d = ST_INSERT;
                            rem_d   = REM_INIT;
                        end
                    end
                end
                ST_INSERT: begin
                    if (is_idle) begin
                        cc_sel = 1'b1;
                        rem_d  = rem_q - 3'd1;
                        if (rem_q == 3'd1) begin
                            state_d = ST_COUNT;
                        end
                    end
                end
                default: begin
                    state_d = ST_COUNT;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_COUNT;
            cnt_q       <= 16'd0;
            rem_q       <= 3'd0;
            cc_active_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rem_q       <= rem_d;
            cc_active_q <= cc_active_d;
        end
    end

    assign cc_active_d   = bus.in_strobe & cc_sel;
    assign payload_sel   = cc_sel ? CC_PAYLOAD : bus.data_in;
    assign bus.cc_active = cc_active_q;
`else
    assign cc_sel        = 1'b0;
    assign payload_sel   = bus.data_in;
    assign bus.cc_active = 1'b0;
`endif

    assign sync_sel = (cc_sel || (bus.ordered_sets != DATA)) ? SYNC_CTRL : SYNC_DATA;

    // Bit 0 goes through first; each scrambled bit is fed back into s[0].
    always_comb begin
        scr_tmp = scr_q;
        scr_out = 64'd0;
        for (int i = 0; i < 64; i++) begin
            scr_out[i] = payload_sel[i] ^ scr_tmp[38] ^ scr_tmp[57];
            scr_tmp    = {scr_tmp[56:0], scr_out[i]};
        end
        scr_d = bus.in_strobe ? scr_tmp : scr_q;
    end

    always_comb begin
        blk_valid_d = bus.in_strobe;
        blk_out_d   = bus.in_strobe ? {sync_sel, scr_out} : blk_out_q;
        lane_mode_d = single_lane;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scr_q       <= SCR_SEED;
            blk_out_q   <= 66'd0;
            blk_valid_q <= 1'b0;
            lane_mode_q <= 1'b0;
        end else begin
            scr_q       <= scr_d;
            blk_out_q   <= blk_out_d;
            blk_valid_q <= blk_valid_d;
            lane_mode_q <= lane_mode_d;
        end
    end

    assign bus.blk_out   = blk_out_q;
    assign bus.blk_valid = blk_valid_q;
    assign lane_mode     = lane_mode_q;

endmodule

`default_nettype wire

// File: doc/tx_block_framer.md
TX_BLOCK_FRAMER -- requirements
Module: tx_block_framer

Interface
REQ-001 SHALL have parameter CC_PERIOD, default 5000, meaning the number of accepted blocks between clock-compensation requests (legal range 8..65535).
REQ-002 SHALL have parameter CC_LEN, default 3, meaning the number of consecutive CC blocks per insertion (legal range 1..7).
REQ-003 SHALL have port clk  input  1  single block clock; all logic runs on its rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port single_lane  input  1  lane mode; echoed on lane_mode, no other effect on framing.
REQ-006 SHALL have port in_strobe  input  1  qualifies ordered_sets/data_in as one block this cycle.
REQ-007 SHALL have port ordered_sets  input  ordered_sets_e (aurora_pkg)  block kind from data_controller.
REQ-008 SHALL have port data_in  input  `AXI_DATA_SIZE (64)  block payload from data_controller.
REQ-009 SHALL have port blk_out  output  66  framed block: [65:64] sync header, [63:0] scrambled payload.
REQ-010 SHALL have port blk_valid  output  1  blk_out holds a new block this cycle.
REQ-011 SHALL have port cc_active  output  1  the block on blk_out is an inserted CC block.
REQ-012 SHALL have port lane_mode  output  1  single_lane registered alongside blk_out.

Function
REQ-013 Latency SHALL be exactly one clk: a strobe in cycle N produces blk_valid=1 in cycle N+1; no strobe gives blk_valid=0.
REQ-014 Sync header SHALL be 2'b01 when ordered_sets==DATA and 2'b10 for every other value and for CC blocks.
REQ-015 Payload SHALL be scrambled with the self-synchronous polynomial x^58+x^39+1, bit 0 first: out[i]=in[i]^s[38]^s[57], with out[i] shifted into s[0].
REQ-016 Scrambler state SHALL advance only on strobed cycles; the sync header SHALL never be scrambled.
REQ-017 CC block pre-scramble payload SHALL be 64'h7880_0000_0000_0000.
REQ-018 A 16-bit block counter SHALL increment on each strobe; on reaching CC_PERIOD-1 it SHALL wrap to 0 and set cc_pending.
REQ-019 The FSM SHALL have states COUNT, PENDING and INSERT: COUNT->PENDING on wrap; PENDING->INSERT on a strobe whose ordered_sets==IDLE; INSERT->COUNT after CC_LEN CC blocks.
REQ-020 In PENDING and INSERT, an IDLE strobe SHALL be replaced by one CC block; a non-IDLE strobe SHALL pass unchanged and SHALL NOT decrement the remaining CC count.
REQ-021 A counter wrap while in PENDING or INSERT SHALL NOT queue a second request, and the counter SHALL keep counting.
REQ-022 Input blocks SHALL never be dropped, duplicated or reordered; CC blocks SHALL only replace IDLE blocks.
REQ-023 A change of single_lane mid-stream SHALL NOT reset the scrambler, the counter or the FSM.

Reset
REQ-024 While rst_n=0, blk_out SHALL be 66'h0, blk_valid=0, cc_active=0 and lane_mode=0.
REQ-025 Reset SHALL clear the counter, clear cc_pending, set the FSM to COUNT and load scrambler state 58'h3FF_FFFF_FFFF_FFFF.
REQ-026 Reset asserted mid-insertion SHALL abandon the remaining CC blocks; the first strobe after release SHALL be framed from the reset seed.

Configuration
REQ-027 Macro CC_INSERT_EN: when defined, REQ-017..REQ-021 SHALL be compiled in.
REQ-028 When CC_INSERT_EN is undefined, the counter and FSM SHALL be absent, cc_active SHALL be tied to 0, and every block SHALL pass through framed and scrambled only.

Verification
REQ-029 Reset release, no strobes -> blk_valid=0 and blk_out=66'h0 on every cycle.
REQ-030 One DATA strobe with data_in=64'hDEADB00DDEADB00D after reset -> next cycle blk_valid=1, blk_out[65:64]=2'b01, blk_out[63:0] equal to the bench's software scrambler model seeded with all-ones.
REQ-031 CC_PERIOD=8, CC_LEN=3, continuous IDLE strobes -> blocks 9..11 have cc_active=1 and sync 2'b10, block 12 is a normal IDLE block.
REQ-032 CC_PERIOD=8, wrap followed by a 5-block DATA burst and then IDLEs -> all 5 DATA blocks are output intact and 3 CC blocks follow the burst.
REQ-033 Reset pulse after the second of three CC blocks -> no further cc_active, outputs zeroed, and the scrambler restarts from the seed on the next strobe.
REQ-034 CC_INSERT_EN undefined, 20 IDLE strobes -> cc_active=0 throughout and 20 valid blocks with sync 2'b10.
